// File: rtl/lnrv_defines.sv
// Shared encodings for the EXU flush controller: redirect sources, FSM states,
// default boot address and the redirect-target helper.
package lnrv_defines;

  typedef enum logic [1:0] {
    FLUSH_SRC_BOOT = 2'd0,
    FLUSH_SRC_EXCP = 2'd1,
    FLUSH_SRC_INT  = 2'd2,
    FLUSH_SRC_BJP  = 2'd3
  } flush_src_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } flush_state_e;

  localparam logic [31:0] LNRV_RESET_PC = 32'h0000_0000;

  // Redirect targets are halfword aligned; the sum wraps silently.
  function automatic logic [31:0] flush_target(input logic [31:0] op1, input logic [31:0] op2);
    logic [31:0] sum;
    sum = op1 + op2;
    return {sum[31:1], 1'b0};
  endfunction

endpackage

// File: rtl/lnrv_flush_arb.sv
// Fixed-priority flush arbiter (excp > int > bjp) with operand mux and
// target adder; purely combinational.
module lnrv_flush_arb
  import lnrv_defines::*;
(
  input  logic        excp_req,
  input  logic [31:0] excp_op1,
  input  logic [31:0] excp_op2,
  input  logic        int_req,
  input  logic [31:0] int_op1,
  input  logic [31:0] int_op2,
  input  logic        bjp_req,
  input  logic [31:0] bjp_op1,
  input  logic [31:0] bjp_op2,
  output logic [2:0]  grant,
  output logic        any,
  output logic [31:0] pc,
  output flush_src_e  src
);

  logic [31:0] op1;
  logic [31:0] op2;

  always_comb begin
    grant = 3'b000;
    src   = FLUSH_SRC_BOOT;
    op1   = 32'h0;
    op2   = 32'h0;
    if (excp_req) begin
      grant = 3'b001;
      src   = FLUSH_SRC_EXCP;
      op1   = excp_op1;
      op2   = excp_op2;
    end else if (int_req) begin
      grant = 3'b010;
      src   = FLUSH_SRC_INT;
      op1   = int_op1;
      op2   = int_op2;
    end else if (bjp_req) begin
      grant = 3'b100;
      src   = FLUSH_SRC_BJP;
      op1   = bjp_op1;
      op2   = bjp_op2;
    end
  end

  assign any = excp_req | int_req | bjp_req;
  assign pc  = flush_target(op1, op2);

endmodule

// File: rtl/lnrv_exu_flush_ctrl.sv
// Pipeline-flush responder: arbitrates flush requests, kills younger work and
// holds the redirect toward the IFU. LNRV_FLUSH_BYPASS_EN enables zero-latency redirect.
module lnrv_exu_flush_ctrl
  import lnrv_defines::*;
#(
  parameter logic [31:0] RESET_PC = LNRV_RESET_PC
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        excp_flush_req,
  output logic        excp_flush_ack,
  input  logic [31:0] excp_flush_pc_op1,
  input  logic [31:0] excp_flush_pc_op2,
  input  logic        int_flush_req,
  output logic        int_flush_ack,
  input  logic [31:0] int_flush_pc_op1,
  input  logic [31:0] int_flush_pc_op2,
  input  logic        bjp_flush_req,
  output logic        bjp_flush_ack,
  input  logic [31:0] bjp_flush_pc_op1,
  input  logic [31:0] bjp_flush_pc_op2,
  output logic        ifu_flush_vld,
  input  logic        ifu_flush_rdy,
  output logic [31:0] ifu_flush_pc,
  output logic [1:0]  ifu_flush_src,
  output logic        pipe_kill,
  output logic        flush_busy
);

  flush_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  flush_src_e   src_q, src_d;

  logic [2:0]   grant;
  logic         any_req;
  logic [31:0]  arb_pc;
  flush_src_e   arb_src;
  logic [2:0]   ack;
  logic         vld;
  logic [31:0]  out_pc;
  flush_src_e   out_src;

  lnrv_flush_arb u_arb (
    .excp_req (excp_flush_req),
    .excp_op1 (excp_flush_pc_op1),
    .excp_op2 (excp_flush_pc_op2),
    .int_req  (int_flush_req),
    .int_op1  (int_flush_pc_op1),
    .int_op2  (int_flush_pc_op2),
    .bjp_req  (bjp_flush_req),
    .bjp_op1  (bjp_flush_pc_op1),
    .bjp_op2  (bjp_flush_pc_op2),
    .grant    (grant),
    .any      (any_req),
    .pc       (arb_pc),
    .src      (arb_src)
  );

  // Reset lands in WAIT so the boot fetch goes out as an ordinary redirect.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_WAIT;
      pc_q    <= RESET_PC;
      src_q   <= FLUSH_SRC_BOOT;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      src_q   <= src_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    src_d     = src_q;
    ack       = 3'b000;
    pipe_kill = 1'b0;
    vld       = (state_q == ST_WAIT);
    out_pc    = pc_q;
    out_src   = src_q;
    case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          ack       = grant;
          pipe_kill = 1'b1;
`ifdef LNRV_FLUSH_BYPASS_EN
          vld     = 1'b1;
          out_pc  = arb_pc;
          out_src = arb_src;
          if (!ifu_flush_rdy) begin
            state_d = ST_WAIT;
            pc_d    = arb_pc;
            src_d   = arb_src;
          end
`else
          state_d = ST_WAIT;
          pc_d    = arb_pc;
          src_d   = arb_src;
`endif
        end
      end
      ST_WAIT: begin
        if (ifu_flush_rdy) state_d = ST_IDLE;
      end
      default: state_d = ST_WAIT;
    endcase
  end

  assign excp_flush_ack = ack[0];
  assign int_flush_ack  = ack[1];
  assign bjp_flush_ack  = ack[2];
  assign ifu_flush_vld  = vld;
  assign ifu_flush_pc   = out_pc;
  assign ifu_flush_src  = out_src;
  assign flush_busy     = (state_q == ST_WAIT);

endmodule

// File: tb/tb_lnrv_exu_flush_ctrl.sv
// Self-checking bench for lnrv_exu_flush_ctrl: directed cases plus random
// requesters/IFU backpressure against an outstanding-redirect model.
module tb_lnrv_exu_flush_ctrl;

  localparam logic [31:0] BOOT_PC = 32'h0000_0000;

  logic        clk;
  logic        reset_n;
  logic [2:0]  req;
  logic [31:0] op1 [3];
  logic [31:0] op2 [3];
  logic        rdy;
  logic        excp_ack, int_ack, bjp_ack;
  logic        vld;
  logic [31:0] pc;
  logic [1:0]  src;
  logic        kill;
  logic        busy;

  int ntests = 0;
  int nfail  = 0;

  // model: one outstanding redirect record plus the last registered target
  bit          m_busy;
  logic [31:0] m_pc;
  logic [1:0]  m_src;
  bit          n_busy;
  logic [31:0] n_pc;
  logic [1:0]  n_src;
  logic [2:0]  e_ack;
  int          ack_log[$];

  lnrv_exu_flush_ctrl dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .excp_flush_req    (req[0]),
    .excp_flush_ack    (excp_ack),
    .excp_flush_pc_op1 (op1[0]),
    .excp_flush_pc_op2 (op2[0]),
    .int_flush_req     (req[1]),
    .int_flush_ack     (int_ack),
    .int_flush_pc_op1  (op1[1]),
    .int_flush_pc_op2  (op2[1]),
    .bjp_flush_req     (req[2]),
    .bjp_flush_ack     (bjp_ack),
    .bjp_flush_pc_op1  (op1[2]),
    .bjp_flush_pc_op2  (op2[2]),
    .ifu_flush_vld     (vld),
    .ifu_flush_rdy     (rdy),
    .ifu_flush_pc      (pc),
    .ifu_flush_src     (src),
    .pipe_kill         (kill),
    .flush_busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_check();
    int          w;
    logic [31:0] tgt;
    bit          hit;
    bit          byp;
    logic        x_vld;
    logic [31:0] x_pc;
    logic [1:0]  x_src;
    w = -1;
    for (int i = 2; i >= 0; i--) if (req[i]) w = i;
    tgt = 32'h0;
    if (w >= 0) begin
      tgt = op1[w] + op2[w];
      tgt[0] = 1'b0;
    end
    hit = !m_busy && (w >= 0);
    e_ack = 3'b000;
    if (hit) e_ack[w] = 1'b1;
`ifdef LNRV_FLUSH_BYPASS_EN
    byp = hit;
`else
    byp = 1'b0;
`endif
    x_vld = m_busy || byp;
    x_pc  = byp ? tgt : m_pc;
    x_src = byp ? 2'(w + 1) : m_src;
    chk("ack", {29'b0, bjp_ack, int_ack, excp_ack}, {29'b0, e_ack});
    chk("pipe_kill", {31'b0, kill}, {31'b0, hit});
    chk("ifu_flush_vld", {31'b0, vld}, {31'b0, x_vld});
    chk("ifu_flush_pc", pc, x_pc);
    chk("ifu_flush_src", {30'b0, src}, {30'b0, x_src});
    chk("flush_busy", {31'b0, busy}, {31'b0, m_busy});
    n_busy = m_busy;
    n_pc   = m_pc;
    n_src  = m_src;
    if (m_busy) begin
      if (rdy) n_busy = 1'b0;
    end else if (hit) begin
      ack_log.push_back(w);
      if (!(byp && rdy)) begin
        n_busy = 1'b1;
        n_pc   = tgt;
        n_src  = 2'(w + 1);
      end
    end
  endtask

  // one clock: compare at negedge, commit model after posedge, retire acked requests
  task automatic tick();
    @(negedge clk);
    model_check();
    @(posedge clk);
    #1;
    m_busy = n_busy;
    m_pc   = n_pc;
    m_src  = n_src;
    for (int i = 0; i < 3; i++) if (e_ack[i]) req[i] = 1'b0;
  endtask

  task automatic model_reset();
    m_busy = 1'b1;
    m_pc   = BOOT_PC;
    m_src  = 2'd0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    chk("rst_vld", {31'b0, vld}, 32'd1);
    chk("rst_pc", pc, BOOT_PC);
    chk("rst_src", {30'b0, src}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd1);
    chk("rst_ack", {29'b0, bjp_ack, int_ack, excp_ack}, 32'd0);
    chk("rst_kill", {31'b0, kill}, 32'd0);
    req = 3'b000;
    rdy = 1'b0;
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b);
    op1[i] = a;
    op2[i] = b;
    req[i] = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0;
    rdy     = 1'b0;
    req     = 3'b000;
    for (int i = 0; i < 3; i++) begin
      op1[i] = 32'h0;
      op2[i] = 32'h0;
    end
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("boot_rst_pc", pc, BOOT_PC);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // boot fetch under backpressure
    repeat (3) tick();
    chk("boot_vld", {31'b0, vld}, 32'd1);
    chk("boot_pc", pc, BOOT_PC);
    chk("boot_src", {30'b0, src}, 32'd0);
    rdy = 1'b1;
    tick();
    chk("boot_vld_after_hs", {31'b0, vld}, 32'd0);

`ifndef LNRV_FLUSH_BYPASS_EN
    // single exception
    set_req(0, 32'h8000_0100, 32'h0);
    #1;
    chk("excp_ack_same_cycle", {31'b0, excp_ack}, 32'd1);
    chk("excp_kill_same_cycle", {31'b0, kill}, 32'd1);
    tick();
    chk("excp_vld", {31'b0, vld}, 32'd1);
    chk("excp_pc", pc, 32'h8000_0100);
    chk("excp_src", {30'b0, src}, 32'd1);
    tick();

    // priority among simultaneous requests
    set_req(0, 32'h0000_0100, 32'h20);
    set_req(1, 32'h0000_0200, 32'h4);
    set_req(2, 32'h0000_0300, 32'h8);
    #1;
    chk("prio_first_ack", {29'b0, bjp_ack, int_ack, excp_ack}, 32'b001);
    ack_log.delete();
    repeat (8) tick();
    chk("prio_ack_count", ack_log.size(), 32'd3);
    if (ack_log.size() == 3) begin
      chk("prio_order0", ack_log[0], 32'd0);
      chk("prio_order1", ack_log[1], 32'd1);
      chk("prio_order2", ack_log[2], 32'd2);
    end

    // wrap-around target
    set_req(2, 32'hFFFF_FFFC, 32'h8);
    tick();
    chk("wrap_pc", pc, 32'h0000_0004);
    chk("wrap_src", {30'b0, src}, 32'd3);
    tick();

    // IFU backpressure with a competing request
    rdy = 1'b0;
    set_req(2, 32'h0000_1000, 32'h0000_0013);
    tick();
    set_req(1, 32'h0000_0400, 32'h0);
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("bp_pc", pc, 32'h0000_1012);
      chk("bp_busy", {31'b0, busy}, 32'd1);
      chk("bp_int_unacked", {31'b0, int_ack}, 32'd0);
      tick();
    end
    rdy = 1'b1;
    tick();
    chk("bp_int_ack_after_hs", {31'b0, int_ack}, 32'd1);
    tick();
    tick();

    // reset while a branch redirect is pending
    rdy = 1'b0;
    set_req(2, 32'h0000_2000, 32'h10);
    tick();
    chk("pend_pc", pc, 32'h0000_2010);
    do_reset();
    rdy = 1'b1;
    tick();
`endif

    // randomized requesters and IFU backpressure
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < 3; i++) begin
        if (!req[i] && $urandom_range(0, 3) == 0) begin
          if ($urandom_range(0, 7) == 0)
            set_req(i, 32'hFFFF_FFF0 | 32'($urandom_range(0, 15)), 32'($urandom_range(0, 63)));
          else
            set_req(i, $urandom, $urandom);
        end
      end
      rdy = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 299) == 0) begin
        do_reset();
        rdy = 1'b1;
      end
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule

// File: doc/lnrv_exu_flush_ctrl.md
Name: lnrv_exu_flush_ctrl

Overview:
- Responder end of the pipeline-flush protocol. Three requesters use it: the exception unit, the interrupt unit and the branch/jump unit.
- Arbitrates among the requesters, acknowledges one per flush and computes the redirect PC (op1+op2).
- Holds the redirect toward the IFU with a valid/ready handshake.
- Kills younger instructions in IDU/EXU.
- After reset it issues the boot fetch to RESET_PC.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address redirected to the IFU after reset.

Ports:
- clk  in  1  core clock
- reset_n  in  1  asynchronous active-low reset
- excp_flush_req  in  1  exception flush request; held until acked
- excp_flush_ack  out  1  exception request accepted
- excp_flush_pc_op1  in  32  exception target operand 1
- excp_flush_pc_op2  in  32  exception target operand 2
- int_flush_req  in  1  interrupt flush request
- int_flush_ack  out  1  interrupt request accepted
- int_flush_pc_op1  in  32  interrupt target operand 1
- int_flush_pc_op2  in  32  interrupt target operand 2
- bjp_flush_req  in  1  branch/jump mispredict flush request
- bjp_flush_ack  out  1  branch request accepted
- bjp_flush_pc_op1  in  32  branch target operand 1
- bjp_flush_pc_op2  in  32  branch target operand 2
- ifu_flush_vld  out  1  redirect valid to IFU
- ifu_flush_rdy  in  1  IFU accepts redirect
- ifu_flush_pc  out  32  redirect PC
- ifu_flush_src  out  2  source of redirect: 0 boot, 1 excp, 2 int, 3 bjp
- pipe_kill  out  1  squash younger instructions in IDU/EXU
- flush_busy  out  1  redirect outstanding toward IFU

Behaviour:
- Clock and reset: one clock clk; reset_n is asynchronous, active-low.
- FSM states:
  - IDLE: no redirect outstanding.
  - WAIT: redirect registered, waiting for ifu_flush_rdy.
- Reset:
  - state=WAIT, ifu_flush_vld=1, ifu_flush_pc=RESET_PC, ifu_flush_src=0, flush_busy=1.
  - All acks=0, pipe_kill=0.
  - Reset asserted mid-operation discards any outstanding redirect and restarts the boot fetch.
- Arbitration (IDLE only), fixed priority excp > int > bjp:
  - The winner's ack is asserted combinationally in the same cycle as its req. The exception unit commits CSRs on that req&ack cycle.
  - Losers see ack=0 and must hold req and operands stable.
- Target computation:
  - pc = (op1 + op2) mod 2^32, with bit 0 forced to 0. Wrap-around is silent.
  - 32'hFFFF_FFFC + 8 = 32'h0000_0004.
- On any ack:
  - pipe_kill=1 in that same cycle, combinational.
  - Target and source are registered.
  - Next cycle: state=WAIT, ifu_flush_vld=1 (one-cycle request-to-vld latency).
- WAIT:
  - All acks=0, pipe_kill=0.
  - ifu_flush_pc and ifu_flush_src are stable while vld=1 and rdy=0.
  - On ifu_flush_vld & ifu_flush_rdy: next state IDLE, vld=0.
  - A request present in the handshake cycle is acked no earlier than the following (IDLE) cycle.
  - No back-to-back ack in the same cycle as IFU acceptance.
- IDLE with no req: all outputs idle; ifu_flush_pc holds its last value.
- flush_busy = (state==WAIT).
- Simultaneous requests: exactly one ack per flush, never more than one ack high in any cycle.

Optional Feature:
- Macro LNRV_FLUSH_BYPASS_EN.
- When defined:
  - In IDLE, the winning request drives ifu_flush_vld, ifu_flush_pc and ifu_flush_src combinationally in the ack cycle (zero latency).
  - If ifu_flush_rdy=1 in that cycle, state stays IDLE and nothing is registered.
  - Otherwise the target is registered and state goes to WAIT, holding the same PC.
- When undefined: registered-only path with the one-cycle latency described above.

Decomposition:
- Shared package lnrv_defines: flush source encodings (FLUSH_SRC_BOOT/EXCP/INT/BJP), default RESET_PC, FSM state encodings.
- One natural sub-module, lnrv_flush_arb: combinational fixed-priority grant plus operand mux and adder, producing grant vector, pc and src.
- The FSM and output registers stay in lnrv_exu_flush_ctrl.

Test Plan:
- Boot: release reset_n with ifu_flush_rdy=0 for 3 cycles, then 1 -> vld=1, pc=RESET_PC, src=0 held steady; vld=0 the cycle after the handshake.
- Single exception: excp req, op1=32'h8000_0100, op2=0, rdy=1 -> excp_flush_ack and pipe_kill high the same cycle; next cycle vld=1, pc=32'h8000_0100, src=1.
- Priority: excp, int and bjp req together -> only excp_flush_ack=1; int acked at the first IDLE after excp's IFU handshake; bjp after int.
- Backpressure: bjp op1=32'h0000_1000, op2=32'h0000_0013, rdy=0 for 5 cycles -> pc=32'h0000_1012 stable, flush_busy=1, a new int req stays un-acked until after the handshake.
- Wrap: op1=32'hFFFF_FFFC, op2=8 -> pc=32'h0000_0004.
- Reset mid-WAIT: assert reset_n=0 while a bjp redirect is pending -> outputs immediately revert to boot values (pc=RESET_PC, src=0).
